// File: rtl/intr_priority_ctrl.sv
// Fixed-priority interrupt controller with an AXI4-Lite register interface.
// Sources latch into ISR; enabled pending bits drive a registered irq and IVR.
module intr_priority_ctrl #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          C_NUM_OF_INTR      = 8,
    parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
    parameter int          C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic [C_NUM_OF_INTR-1:0]          intr,
    output logic                              irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready
);
    localparam int             N         = C_NUM_OF_INTR;
    localparam logic           IRQ_ON    = (C_IRQ_ACTIVE_STATE != 0);
    localparam logic [N-1:0]   EDGE_MODE = C_INTR_SENSITIVITY[N-1:0];

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;
    logic        gier_q, gier_d;
    logic [N-1:0] ier_q, ier_d;
    logic [N-1:0] isr_q, isr_d;
    logic [N-1:0] intr_prev_q, intr_prev_d;
    logic [31:0] ivr_q, ivr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;

    logic [N-1:0] ipr;
    logic [N-1:0] intr_set;
    logic [N-1:0] isr_clr;
    logic [31:0]  reg_view [8];
    logic [31:0]  wr_val;
    logic [31:0]  clr_val;
    logic         unused_bits;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    assign ipr      = isr_q & ier_q;
    // Edge-mode bits need a 0 in the previous sample; level-mode bits set whenever high.
    assign intr_set = intr & ~(EDGE_MODE & intr_prev_q);

    always_comb begin
        reg_view[0] = {31'b0, gier_q};
        reg_view[1] = 32'(ier_q);
        reg_view[2] = 32'(isr_q);
        reg_view[3] = 32'h0;
        reg_view[4] = 32'(ipr);
        reg_view[5] = ivr_q;
        reg_view[6] = 32'h0;
        reg_view[7] = 32'h0;
    end

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        gier_d      = gier_q;
        ier_d       = ier_q;
        isr_clr     = '0;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        wr_val      = apply_strb(reg_view[s_axi_awaddr[4:2]], s_axi_wdata, s_axi_wstrb);
        clr_val     = apply_strb(32'h0, s_axi_wdata, s_axi_wstrb);

        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_ACK;
                    case (s_axi_awaddr[4:2])
                        3'd0:    gier_d  = wr_val[0];
                        3'd1:    ier_d   = wr_val[N-1:0];
                        3'd3:    isr_clr = clr_val[N-1:0];
                        default: ;
                    endcase
                end
            end
            W_ACK: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // rdata is captured from current register state, so a same-edge write is not seen.
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    arready_d = 1'b1;
                    rdata_d   = reg_view[s_axi_araddr[4:2]];
                    r_state_d = R_ACK;
                end
            end
            R_ACK: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        isr_d       = (isr_q & ~isr_clr) | intr_set;
        intr_prev_d = intr;
        irq_d       = (gier_q && (|ipr)) ? IRQ_ON : ~IRQ_ON;
        ivr_d       = 32'hFFFFFFFF;
        for (int i = N - 1; i >= 0; i--) begin
            if (ipr[i]) ivr_d = 32'(i);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            gier_q      <= 1'b0;
            ier_q       <= '0;
            isr_q       <= '0;
            intr_prev_q <= '0;
            ivr_q       <= 32'hFFFFFFFF;
            rdata_q     <= 32'h0;
            irq_q       <= ~IRQ_ON;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            gier_q      <= gier_d;
            ier_q       <= ier_d;
            isr_q       <= isr_d;
            intr_prev_q <= intr_prev_d;
            ivr_q       <= ivr_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign irq           = irq_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = rdata_q;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], wr_val, clr_val};
endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Self-checking bench for intr_priority_ctrl: AXI reads are scored against a
// queue of expected values; irq and handshake signals are checked inline.
module tb_intr_priority_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  intr = '0;
    logic        irq;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  last_bresp, last_rresp;

    // Bit 7 is level-sensitive; all other sources are rising-edge.
    intr_priority_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .C_NUM_OF_INTR(8),
        .C_INTR_SENSITIVITY(32'hFFFFFF7F),
        .C_IRQ_ACTIVE_STATE(1)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .intr(intr), .irq(irq),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL write_ready_timeout addr=%h", a);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL write_resp_timeout addr=%h", a);
        end
        last_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL read_ready_timeout addr=%h", a);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL read_data_timeout addr=%h", a);
        end
        d = rdata;
        last_rresp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        apply_reset();
        checks++;
        if (irq !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got irq=%b bvalid=%b rvalid=%b awready=%b arready=%b expected all 0",
                     irq, bvalid, rvalid, awready, arready);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i == 5) ? 32'hFFFFFFFF : 32'h0);
            do_read(5'(i * 4), got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset_read_%0h got=%h expected=%h", i * 4, got, e);
            end
        end
        checks++;
        if (last_rresp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rresp got=%b expected=00", last_rresp);
        end
        do_write(5'h18, 32'hDEADBEEF, 4'hF);
        checks++;
        if (last_bresp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bresp got=%b expected=00", last_bresp);
        end
    endtask

    task automatic test_single_source();
        logic [31:0] got, e;
        logic [4:0]  addrs [3] = '{5'h08, 5'h10, 5'h14};
        logic [31:0] exps  [3] = '{32'h1, 32'h1, 32'h0};
        do_write(5'h00, 32'h1, 4'hF);
        do_write(5'h04, 32'h1, 4'hF);
        @(posedge clk); #1;
        intr[0] = 1'b1;
        @(posedge clk); #1;
        intr[0] = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_same_edge_as_isr got=%b expected=0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_latency got=%b expected=1", irq);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            do_read(addrs[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL single_read_%0h got=%h expected=%h", addrs[i], got, e);
            end
        end
        do_write(5'h0C, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack_irq got=%b expected=0", irq);
        end
        exp_q.push_back(32'h0);
        do_read(5'h08, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL single_isr_cleared got=%h expected=%h", got, e);
        end
    endtask

    task automatic test_priority();
        logic [31:0] got, e;
        logic [4:0]  addrs [5] = '{5'h10, 5'h14, 5'h14, 5'h14, 5'h08};
        logic [31:0] acks  [5] = '{32'h0, 32'h0, 32'h04, 32'h20, 32'h0};
        logic [31:0] exps  [5] = '{32'h24, 32'h2, 32'h5, 32'hFFFFFFFF, 32'h0};
        do_write(5'h04, 32'hFF, 4'hF);
        @(posedge clk); #1;
        intr = 8'h24;
        @(posedge clk); #1;
        intr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (acks[i] != 0) do_write(5'h0C, acks[i], 4'hF);
            exp_q.push_back(exps[i]);
            do_read(addrs[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL priority_step%0d got=%h expected=%h", i, got, e);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL priority_all_acked_irq got=%b expected=0", irq);
        end
    endtask

    task automatic test_masked();
        logic [31:0] got, e;
        do_write(5'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        intr[3] = 1'b1;
        @(posedge clk); #1;
        intr[3] = 1'b0;
        exp_q.push_back(32'h08);
        do_read(5'h08, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL masked_isr got=%h expected=%h", got, e);
        end
        exp_q.push_back(32'h0);
        do_read(5'h10, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked_ipr got=%h irq=%b expected=%h irq=0", got, irq, e);
        end
        do_write(5'h04, 32'h08, 4'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL masked_enable_irq got=%b expected=1", irq);
        end
        do_write(5'h0C, 32'h08, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked_ack_irq got=%b expected=0", irq);
        end
    endtask

    task automatic test_level();
        logic [31:0] got, e;
        do_write(5'h04, 32'h80, 4'hF);
        @(posedge clk); #1;
        intr[7] = 1'b1;
        do_write(5'h0C, 32'h80, 4'hF);
        exp_q.push_back(32'h80);
        do_read(5'h08, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL level_reset_on_ack got=%h irq=%b expected=%h irq=1", got, irq, e);
        end
        intr[7] = 1'b0;
        do_write(5'h0C, 32'h80, 4'hF);
        exp_q.push_back(32'h0);
        do_read(5'h08, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL level_dropped_ack got=%h irq=%b expected=%h irq=0", got, irq, e);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] got, e;
        logic [4:0]  addrs [4] = '{5'h04, 5'h00, 5'h1C, 5'h0C};
        logic [31:0] exps  [4] = '{32'hA5, 32'h1, 32'h0, 32'h0};
        do_write(5'h04, 32'h0, 4'hF);
        do_write(5'h04, 32'hFFFFFFA5, 4'h1);
        do_write(5'h04, 32'hFFFFFFFF, 4'h2);
        do_write(5'h00, 32'h0, 4'h0);
        do_write(5'h1C, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            do_read(addrs[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL strobe_read_%0h got=%h expected=%h", addrs[i], got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e;
        logic        seen_ready = 1'b0;
        logic        bvalid_dropped = 1'b0;
        int          n;
        @(posedge clk); #1;
        awaddr = 5'h04; wdata = 32'h3C; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (awready || wready) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addr_only_accepted got=1 expected=0");
        end
        wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) begin
            if (!bvalid) bvalid_dropped = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bvalid_dropped !== 1'b0 || bvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bvalid_hold got dropped=%b bvalid=%b expected dropped=0 bvalid=1", bvalid_dropped, bvalid);
        end
        exp_q.push_back(32'h3C);
        do_read(5'h04, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || bvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_during_resp got=%h bvalid=%b expected=%h bvalid=1", got, bvalid, e);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_resp bvalid got=%b expected=0", bvalid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        do_read(5'h04, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL ier_after_reset got=%h expected=%h", got, e);
        end
    endtask

    initial begin
        $display("[TB] starting intr_priority_ctrl bench");
        test_reset();
        test_single_source();
        test_priority();
        test_masked();
        test_level();
        test_strobes();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
